v_lane_seq: RTL
===============

# v_lane_seq

Parametrised lane sequencer for the vector coprocessor. Accepts one vector operation over a register group of up to NUM_REGS source registers, slices operands into beats of NUM_LANES 32-bit elements, issues one beat per cycle to the ALU or MUL lanes, collects returning lane results into a group-wide result buffer and hands the buffer back with a valid/ready handshake. Sits between decode/operand fetch and the lane array.

## Interface

- NUM_LANES, 4, 32-bit lanes fed per beat; must divide VLEN/32
- VLEN, 128, bits per vector register
- NUM_REGS, 4, maximum registers per group (LMUL limit)
- RCW, $clog2(NUM_REGS)+1, width of reg_cnt
- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset, asynchronous, active-high (1 = reset)
- in_valid  in  1  operation offered
- in_ready  out  1  sequencer can accept an operation
- op_instr  in  6  operation code, forwarded to lanes
- unit_sel  in  1  0 = ALU lanes, 1 = MUL lanes
- vsew  in  3  element width code, forwarded to lanes
- reg_cnt  in  RCW  registers in group, 1..NUM_REGS
- op_A  in  NUM_REGS*VLEN  operand A group, register 0 in LSBs
- op_B  in  NUM_REGS*VLEN  operand B group
- lane_op_A  out  NUM_LANES*32  current beat of A
- lane_op_B  out  NUM_LANES*32  current beat of B
- lane_op_instr  out  6  latched op_instr
- lane_vsew  out  3  latched vsew
- lane_alu_valid  out  1  beat issued to ALU lanes
- lane_mul_valid  out  1  beat issued to MUL lanes
- lane_res  in  NUM_LANES*32  returned beat
- lane_res_valid  in  1  lane_res valid this cycle; beats return in issue order
- out_valid  out  1  result buffer complete
- out_ready  in  1  consumer takes result
- result  out  NUM_REGS*VLEN  collected results
- err_spurious  out  1  one-cycle pulse: lane_res_valid with no beat outstanding

## Operation

- BEATS = reg_cnt*VLEN/(32*NUM_LANES); reg_cnt 0 treated as 1, above NUM_REGS clamped to NUM_REGS.
- FSM states IDLE, ISSUE, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid: latch op_instr, vsew, unit_sel, op_A, op_B, BEATS; clear issue count, return count and result buffer to 0; go ISSUE.
- ISSUE: drive beat k = bits [k*NUM_LANES*32 +: NUM_LANES*32] of latched A/B; assert lane_alu_valid or lane_mul_valid per unit_sel; increment issue count; after beat BEATS-1 go DRAIN.
- Collection active in ISSUE and DRAIN: on lane_res_valid, write lane_res into result slot = return count, increment. When return count reaches BEATS, go DONE (from DRAIN; lanes have latency ≥1 so completion never occurs in ISSUE).
- DONE: out_valid=1, result stable; on out_ready go IDLE. Slots beyond BEATS read 0.
- lane_res_valid in IDLE/DONE, or in ISSUE/DRAIN with return count = issue count: ignored, err_spurious pulses.
- Lane outputs hold last values when no valid is asserted; only the valid strobes are meaningful.

## Timing

- Reset values: in_ready=1, out_valid=0, lane_alu_valid=0, lane_mul_valid=0, err_spurious=0, result=0, lane_op_A/B=0, lane_op_instr=0, lane_vsew=0; state IDLE.
- Accept at edge T; beat k issued in cycle T+1+k, one beat per cycle, no bubbles.
- Beat returning in cycle R is captured at end of R; out_valid rises cycle R+1 after final return.
- Lane latency L, BEATS=1: accept T, issue T+1, return T+1+L, out_valid T+2+L.
- Back-to-back: out_ready in DONE returns to IDLE next cycle; next accept one cycle later (no accept in DONE).
- nrst mid-operation: immediate abort to reset values; late lane returns after reset pulse err_spurious.

## Structure

- Shared package v_pkg: WORD_W=32, state enum (IDLE, ISSUE, DRAIN, DONE), unit_sel encoding (UNIT_ALU=0, UNIT_MUL=1).
- One sub-module: v_result_buf, NUM_REGS*VLEN buffer with clear, slot write-enable and slot index; FSM and beat slicing stay in v_lane_seq.

## Test plan

- Reset mid-ISSUE (NUM_LANES=4, reg_cnt=4) -> all outputs reset values next cycle, in_ready=1, no further valid strobes.
- reg_cnt=1, unit_sel=0, op_A reg0 = 0x00000004_00000003_00000002_00000001, lane model adds op_B=1 per word, L=2 -> one lane_alu_valid at T+1, out_valid at T+4, result[127:0]=0x00000005_00000004_00000003_00000002, result[511:128]=0.
- reg_cnt=4, unit_sel=1, L=3 -> four consecutive lane_mul_valid cycles, zero lane_alu_valid, out_valid at T+8, each 128-bit slot equals model product.
- NUM_LANES=2, reg_cnt=2 -> 4 beats, beat k carries words 2k..2k+1, result matches word-wise model.
- out_ready held low 10 cycles in DONE -> out_valid and result stable, in_ready=0, new in_valid ignored; then out_ready=1 -> IDLE, next op accepted.
- lane_res_valid in IDLE -> err_spurious=1 one cycle, result unchanged; reg_cnt=0 -> behaves as reg_cnt=1.

Source files
------------

// File: rtl/v_pkg.sv
// Shared definitions for the vector lane sequencer: word width, FSM states
// and the functional-unit select encoding.
package v_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam logic UNIT_ALU = 1'b0;
  localparam logic UNIT_MUL = 1'b1;

endpackage

// File: rtl/v_result_buf.sv
// Group-wide result buffer: one slot per beat, cleared at the start of an
// operation and written one slot at a time as lane results return.
module v_result_buf #(
  parameter int SLOTS  = 4,
  parameter int SLOT_W = 128,
  parameter int IW     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clear,
  input  logic                    i_we,
  input  logic [IW-1:0]           i_idx,
  input  logic [SLOT_W-1:0]       i_data,
  output logic [SLOTS*SLOT_W-1:0] o_buf
);

  logic [SLOT_W-1:0] r_slot [SLOTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) r_slot[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < SLOTS; i++) r_slot[i] <= '0;
    end else if (i_we) begin
      r_slot[i_idx] <= i_data;
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_pack
    assign o_buf[g*SLOT_W +: SLOT_W] = r_slot[g];
  end

endmodule

// File: rtl/v_lane_seq.sv
// Lane sequencer: slices a register group into beats, issues one beat per
// cycle to the ALU or MUL lanes and gathers in-order lane results.
module v_lane_seq
  import v_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int VLEN      = 128,
  parameter int NUM_REGS  = 4,
  parameter int RCW       = $clog2(NUM_REGS) + 1
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [5:0]                op_instr,
  input  logic                      unit_sel,
  input  logic [2:0]                vsew,
  input  logic [RCW-1:0]            reg_cnt,
  input  logic [NUM_REGS*VLEN-1:0]  op_A,
  input  logic [NUM_REGS*VLEN-1:0]  op_B,
  output logic [NUM_LANES*32-1:0]   lane_op_A,
  output logic [NUM_LANES*32-1:0]   lane_op_B,
  output logic [5:0]                lane_op_instr,
  output logic [2:0]                lane_vsew,
  output logic                      lane_alu_valid,
  output logic                      lane_mul_valid,
  input  logic [NUM_LANES*32-1:0]   lane_res,
  input  logic                      lane_res_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_REGS*VLEN-1:0]  result,
  output logic                      err_spurious
);

  localparam int BEAT_W        = NUM_LANES * WORD_W;
  localparam int BEATS_PER_REG = VLEN / BEAT_W;
  localparam int MAX_BEATS     = NUM_REGS * BEATS_PER_REG;
  localparam int BCW           = $clog2(MAX_BEATS + 1);
  localparam int IW            = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int GRP_W         = NUM_REGS * VLEN;
  localparam logic [RCW-1:0] MAX_REGS = RCW'(NUM_REGS);

  state_t             r_state, w_next_state;
  logic [5:0]         r_instr;
  logic [2:0]         r_vsew;
  logic               r_unit;
  logic [GRP_W-1:0]   r_opA, r_opB;
  logic [BCW-1:0]     r_beats, r_issue_cnt, r_ret_cnt;
  logic               r_err;

  logic [RCW-1:0]     w_regs;
  logic [BCW-1:0]     w_beats, w_issue_idx, w_ret_next;
  logic               w_accept, w_res_accept;
  logic [BEAT_W-1:0]  w_beat_a [MAX_BEATS];
  logic [BEAT_W-1:0]  w_beat_b [MAX_BEATS];

  // Out-of-range register counts are folded into 1..NUM_REGS before sizing.
  always_comb begin
    w_regs = reg_cnt;
    if (reg_cnt == '0) w_regs = RCW'(1);
    else if (reg_cnt > MAX_REGS) w_regs = MAX_REGS;
  end

  assign w_beats      = BCW'(w_regs) * BCW'(BEATS_PER_REG);
  assign w_accept     = (r_state == IDLE) && in_valid;
  assign w_res_accept = lane_res_valid && (r_state == ISSUE || r_state == DRAIN)
                        && (r_ret_cnt != r_issue_cnt);
  assign w_ret_next   = r_ret_cnt + BCW'(1);

  // Once every beat has gone out, keep presenting the last one.
  always_comb begin
    w_issue_idx = r_issue_cnt;
    if (r_issue_cnt != '0 && r_issue_cnt >= r_beats) w_issue_idx = r_issue_cnt - BCW'(1);
  end

  for (genvar g = 0; g < MAX_BEATS; g++) begin : g_beat
    assign w_beat_a[g] = r_opA[g*BEAT_W +: BEAT_W];
    assign w_beat_b[g] = r_opB[g*BEAT_W +: BEAT_W];
  end

  assign lane_op_A     = w_beat_a[IW'(w_issue_idx)];
  assign lane_op_B     = w_beat_b[IW'(w_issue_idx)];
  assign lane_op_instr = r_instr;
  assign lane_vsew     = r_vsew;
  assign err_spurious  = r_err;

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = ISSUE;
      ISSUE:   if (r_issue_cnt == r_beats - BCW'(1)) w_next_state = DRAIN;
      DRAIN:   if (w_res_accept && w_ret_next == r_beats) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready       = (r_state == IDLE);
    out_valid      = (r_state == DONE);
    lane_alu_valid = (r_state == ISSUE) && (r_unit == UNIT_ALU);
    lane_mul_valid = (r_state == ISSUE) && (r_unit == UNIT_MUL);
  end

  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_instr     <= '0;
      r_vsew      <= '0;
      r_unit      <= UNIT_ALU;
      r_opA       <= '0;
      r_opB       <= '0;
      r_beats     <= '0;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr     <= op_instr;
        r_vsew      <= vsew;
        r_unit      <= unit_sel;
        r_opA       <= op_A;
        r_opB       <= op_B;
        r_beats     <= w_beats;
        r_issue_cnt <= '0;
        r_ret_cnt   <= '0;
      end else begin
        if (r_state == ISSUE) r_issue_cnt <= r_issue_cnt + BCW'(1);
        if (w_res_accept) r_ret_cnt <= w_ret_next;
      end
      r_err <= lane_res_valid && !w_res_accept;
    end
  end

  v_result_buf #(
    .SLOTS (MAX_BEATS),
    .SLOT_W(BEAT_W),
    .IW    (IW)
  ) u_result_buf (
    .clk    (clk),
    .rst    (nrst),
    .i_clear(w_accept),
    .i_we   (w_res_accept),
    .i_idx  (IW'(r_ret_cnt)),
    .i_data (lane_res),
    .o_buf  (result)
  );

endmodule
